inv_mix_column: RTL and testbench
=================================

INV_MIX_COLUMN -- requirements
Module: inv_mix_column

Interface
REQ-001 The block SHALL have parameter INVERSE, default 1, meaning 1 = AES InvMixColumns and 0 = forward MixColumns on the same datapath.
REQ-002 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: col_in is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a column.
REQ-006 The block SHALL have port col_in, input, 32 bits: column bytes a0..a3, with a0 = [31:24] (row 0) and a3 = [7:0].
REQ-007 The block SHALL have port out_valid, output, 1 bit: col_out is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts col_out.
REQ-009 The block SHALL have port col_out, output, 32 bits: result bytes b0..b3, packed in the same order as col_in.

Function
REQ-010 The block SHALL implement the FSM states IDLE, X2, X4, X8, COMB and HOLD.
REQ-011 The block SHALL assert in_ready only in IDLE, combinationally from the state register.
REQ-012 The block SHALL treat the input handshake as in_valid && in_ready at a rising edge, capturing col_in into register A and moving IDLE->X2.
REQ-013 In state X2, the block SHALL register T2[i] = xtime(A[i]) for all 4 bytes and move to X4.
  - xtime(x) = (x<<1)[7:0] XOR (x[7] ? 8'h1B : 8'h00).
REQ-014 In state X4, the block SHALL register T4[i] = xtime(T2[i]) and move to X8.
REQ-015 In state X8, the block SHALL register T8[i] = xtime(T4[i]) and move to COMB.
REQ-016 When INVERSE=1, the COMB state SHALL register the products 9x = T8^A, 11x = T8^T2^A, 13x = T8^T4^A and 14x = T8^T4^T2.
  - b0 = 14a0^11a1^13a2^9a3
  - b1 = 9a0^14a1^11a2^13a3
  - b2 = 13a0^9a1^14a2^11a3
  - b3 = 11a0^13a1^9a2^14a3
REQ-017 When INVERSE=0, the COMB state SHALL register b_i = 2a_i ^ 3a_(i+1) ^ a_(i+2) ^ a_(i+3), indices mod 4 and 3x = T2^A, with X4 and X8 still traversed so latency is identical.
REQ-018 From COMB, the block SHALL go to HOLD and set out_valid=1 with col_out registered.
REQ-019 The latency SHALL be fixed:
  - input handshake at edge k -> out_valid=1 after edge k+4.
  - no early output.
REQ-020 In HOLD, the block SHALL keep col_out and out_valid stable while out_ready=0 (no limit on stall duration).
REQ-021 When out_valid && out_ready at an edge, the block SHALL clear out_valid and return to IDLE, so in_ready=1 in the next cycle.
  - Throughput: at most 1 column per 6 cycles.
REQ-022 The block SHALL ignore in_valid in every state except IDLE; col_in changes in non-IDLE states SHALL NOT affect the result.
REQ-023 The block SHALL NOT react to out_ready outside HOLD.
REQ-024 All arithmetic SHALL be GF(2^8) with polynomial 0x11B and 8-bit results only (no carries beyond bit 7).

Reset
REQ-025 While rst=1, the block SHALL hold state=IDLE, in_ready=1, out_valid=0, col_out=32'h0, and A, T2, T4, T8 = 0.
REQ-026 If rst asserts mid-operation (any state), the block SHALL abort the in-flight column immediately; no out_valid is produced for it after rst deasserts.
REQ-027 After rst deasserts, the first input handshake SHALL be accepted on the first rising edge at which in_valid=1.

Verification
REQ-028 The bench SHALL cover the standard vector, INVERSE=1:
  - col_in=32'h8E4DA1BC -> col_out=32'hDB135345, out_valid exactly 4 edges after acceptance.
REQ-029 The bench SHALL cover two more vectors, INVERSE=1:
  - 32'h9FDC589D -> 32'hF20A225C
  - 32'h4D7EBDF8 -> 32'h2D26314C
REQ-030 The bench SHALL cover the identity/forward cases:
  - INVERSE=1: 32'h01010101 -> 32'h01010101 and 32'hC6C6C6C6 -> 32'hC6C6C6C6
  - INVERSE=0: 32'hDB135345 -> 32'h8E4DA1BC
REQ-031 The bench SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid.
  - col_out stays constant and in_ready stays 0.
  - Raising out_ready -> one transfer, then in_ready=1 on the next cycle.
REQ-032 The bench SHALL cover input ignore: in_valid held 1 with col_in changing every cycle during X2..HOLD.
  - Result equals that of the first accepted column only.
REQ-033 The bench SHALL cover mid-operation reset: rst pulse during state X4.
  - out_valid=0, col_out=0, in_ready=1.
  - The next column 32'h8E4DA1BC completes correctly with the nominal latency.

Source files
------------

// File: rtl/inv_mix_column.sv
// AES (Inv)MixColumns on a single 32-bit column, computed as a short
// multi-cycle pipeline of xtime doublings followed by one XOR-combine step.
// INVERSE=1 yields InvMixColumns, INVERSE=0 forward MixColumns; both use the
// same state sequence so latency is identical.
module inv_mix_column #(
  parameter int INVERSE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] col_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] col_out
);

  typedef enum logic [2:0] {
    IDLE,
    X2,
    X4,
    X8,
    COMB,
    HOLD
  } state_t;

  // Index 0 of each packed array is the most significant byte (row 0).
  typedef logic [0:3][7:0] column_t;

  state_t  state;
  column_t a;
  column_t t2;
  column_t t4;
  column_t t8;

  column_t nx_t2;
  column_t nx_t4;
  column_t nx_t8;
  column_t inv_res;
  column_t fwd_res;
  column_t comb_res;

  // Multiply by x in GF(2^8) modulo 0x11B; the result stays 8 bits wide.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  assign in_ready = (state == IDLE);

  // Doubling stages and the two candidate combine results, all from registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    nx_t2   = '0;
    nx_t4   = '0;
    nx_t8   = '0;
    inv_res = '0;
    fwd_res = '0;
    for (int i = 0; i < 4; i++) begin
      nx_t2[i] = xtime(a[i]);
      nx_t4[i] = xtime(t2[i]);
      nx_t8[i] = xtime(t4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      // b_i = 14a_i ^ 11a_(i+1) ^ 13a_(i+2) ^ 9a_(i+3)
      inv_res[i] = (t8[i] ^ t4[i] ^ t2[i])
                 ^ (t8[2'(i + 1)] ^ t2[2'(i + 1)] ^ a[2'(i + 1)])
                 ^ (t8[2'(i + 2)] ^ t4[2'(i + 2)] ^ a[2'(i + 2)])
                 ^ (t8[2'(i + 3)] ^ a[2'(i + 3)]);
      // b_i = 2a_i ^ 3a_(i+1) ^ a_(i+2) ^ a_(i+3)
      fwd_res[i] = t2[i]
                 ^ (t2[2'(i + 1)] ^ a[2'(i + 1)])
                 ^ a[2'(i + 2)]
                 ^ a[2'(i + 3)];
    end
    comb_res = (INVERSE != 0) ? inv_res : fwd_res;
  end

  // Control FSM and datapath registers; reset aborts any column in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      t2        <= '0;
      t4        <= '0;
      t8        <= '0;
      col_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= col_in;
            state <= X2;
          end
        end
        X2: begin
          t2    <= nx_t2;
          state <= X4;
        end
        X4: begin
          t4    <= nx_t4;
          state <= X8;
        end
        X8: begin
          t8    <= nx_t8;
          state <= COMB;
        end
        COMB: begin
          col_out   <= comb_res;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mix_column.sv
// Directed bench for inv_mix_column: known AES vectors, latency, backpressure,
// input-ignore and mid-operation reset. One inverse and one forward instance
// share all inputs and run in lockstep.
module tb_inv_mix_column;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] col_in;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] col_out1;
  logic        in_ready0, out_valid0;
  logic [31:0] col_out0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inv_mix_column #(.INVERSE(1)) u_inv (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready1),
    .col_in   (col_in),
    .out_valid(out_valid1),
    .out_ready(out_ready),
    .col_out  (col_out1)
  );

  inv_mix_column #(.INVERSE(0)) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready0),
    .col_in   (col_in),
    .out_valid(out_valid0),
    .out_ready(out_ready),
    .col_out  (col_out0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Count edges after acceptance until out_valid shows; 0 means it never did.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Push one column, check latency and result(s), then drain it.
  task automatic run(input string tag, input logic [31:0] col,
                     input bit chk_inv, input logic [31:0] exp_inv,
                     input bit chk_fwd, input logic [31:0] exp_fwd);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready1, 1);
    in_valid = 1'b1;
    col_in   = col;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    check({tag, "_latency"}, lat, 4);
    if (chk_inv) check({tag, "_inv"}, col_out1, exp_inv);
    if (chk_fwd) begin
      check({tag, "_fwd_valid"}, out_valid0, 1);
      check({tag, "_fwd"}, col_out0, exp_fwd);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drained"}, out_valid1, 0);
    check({tag, "_ready_again"}, in_ready1, 1);
  endtask

  initial begin
    int  lat;
    bit  seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    col_in    = 32'h0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready1, 1);
    check("rst_out_valid", out_valid1, 0);
    check("rst_col_out", col_out1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Known vectors and identity / forward cases
    run("std",  32'h8E4DA1BC, 1, 32'hDB135345, 0, 32'h0);
    run("vec2", 32'h9FDC589D, 1, 32'hF20A225C, 0, 32'h0);
    run("vec3", 32'h4D7EBDF8, 1, 32'h2D26314C, 0, 32'h0);
    run("id01", 32'h01010101, 1, 32'h01010101, 1, 32'h01010101);
    run("idC6", 32'hC6C6C6C6, 1, 32'hC6C6C6C6, 1, 32'hC6C6C6C6);
    run("fwd",  32'hDB135345, 0, 32'h0,        1, 32'h8E4DA1BC);

    // Backpressure: ten stalled cycles in HOLD
    @(negedge clk);
    in_valid = 1'b1;
    col_in   = 32'h9FDC589D;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_col_out", col_out1, 32'hF20A225C);
      check("bp_out_valid", out_valid1, 1);
      check("bp_in_ready", in_ready1, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_transfer", out_valid1, 0);
    check("bp_ready_next", in_ready1, 1);

    // Input ignore: in_valid stays high and col_in churns after acceptance
    @(negedge clk);
    in_valid = 1'b1;
    col_in   = 32'h4D7EBDF8;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      col_in = 32'hA5A50000 + 32'(i * 32'h01010101);
      @(posedge clk);
      #1;
      if (out_valid1) begin
        lat = i;
        break;
      end
    end
    check("ign_latency", lat, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      col_in = col_in ^ 32'hFFFF00FF;
      @(posedge clk);
      #1;
    end
    check("ign_col_out", col_out1, 32'h2D26314C);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ign_drained", out_valid1, 0);

    // Mid-operation reset while in X4
    @(negedge clk);
    in_valid = 1'b1;
    col_in   = 32'hC6C6C6C6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid1, 0);
    check("mrst_col_out", col_out1, 32'h0);
    check("mrst_in_ready", in_ready1, 1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid1) seen = 1'b1;
    end
    check("mrst_no_output", seen, 0);
    run("post_rst", 32'h8E4DA1BC, 1, 32'hDB135345, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
